serial_word_tx: RTL and testbench

- Parallel-to-serial word transmitter that drives `d_in` of the 16-bit serial-in shift register stage.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per `SC` cycle.
- Marks valid bit cycles with `shift_en`, which enables the downstream stage's shift.
- Pulses `frame_done` once the downstream register holds the complete word.

---
 rtl/serial_word_tx.sv | 95 +++++++++
 tb/tb_serial_word_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: accepts a WIDTH-bit word and shifts it out MSB-first.
// Define SER_SKID_EN to add a one-word hold buffer, so that frames follow each other with no gap cycle.
module serial_word_tx #(
    parameter int WIDTH = 16
) (
    input  logic             SC,
    input  logic             RESET,
    input  logic [WIDTH-1:0] word_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             d_out,
    output logic             shift_en,
    output logic             frame_done
);

    // state | meaning
    // IDLE  | no frame in flight, d_out/shift_en low
    // SHIFT | driving sreg MSB on d_out, one bit per SC cycle
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    bit_cnt;
    logic             xfer;

`ifdef SER_SKID_EN
    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;

    assign load_ready = !hold_valid && !RESET;
`else
    assign load_ready = (state == IDLE) && !RESET;
`endif

    assign xfer     = load_valid && load_ready;
    assign shift_en = (state == SHIFT);
    assign d_out    = (state == SHIFT) && sreg[WIDTH-1];

    always_ff @(posedge SC or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
`ifdef SER_SKID_EN
            hold_data  <= '0;
            hold_valid <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        sreg    <= word_in;
                        bit_cnt <= LAST;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg    <= {sreg[WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt - CW'(1);
                    if (bit_cnt == '0) begin
                        frame_done <= 1'b1;
`ifdef SER_SKID_EN
                        // Chain the next frame straight onto the last bit edge.
                        if (hold_valid) begin
                            sreg       <= hold_data;
                            bit_cnt    <= LAST;
                            hold_valid <= 1'b0;
                        end else if (xfer) begin
                            sreg    <= word_in;
                            bit_cnt <= LAST;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
`ifdef SER_SKID_EN
                    else if (xfer) begin
                        hold_data  <= word_in;
                        hold_valid <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: a 16-bit instance feeding a downstream shift-register model, plus an 8-bit instance.
module tb_serial_word_tx;

    logic        sc = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] word_in = '0;
    logic        load_valid = 1'b0;
    logic        load_ready, d_out, shift_en, frame_done;

    logic [7:0]  w8_word = '0;
    logic        w8_valid = 1'b0;
    logic        w8_ready, w8_dout, w8_sen, w8_fd;

    logic [15:0] q_ds = '0;
    logic [15:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          xfer_cnt = 0;
    int          fd_count = 0;
    logic        fd_prev = 1'b0;

`ifdef SER_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif

    serial_word_tx #(.WIDTH(16)) dut (
        .SC(sc), .RESET(rst), .word_in(word_in), .load_valid(load_valid),
        .load_ready(load_ready), .d_out(d_out), .shift_en(shift_en), .frame_done(frame_done)
    );

    serial_word_tx #(.WIDTH(8)) dut8 (
        .SC(sc), .RESET(rst), .word_in(w8_word), .load_valid(w8_valid),
        .load_ready(w8_ready), .d_out(w8_dout), .shift_en(w8_sen), .frame_done(w8_fd)
    );

    always #5 sc = ~sc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Downstream serial-in register model
    always @(posedge sc) if (shift_en) q_ds <= {q_ds[14:0], d_out};

    // Scoreboard push on every accepted word
    always @(posedge sc) begin
        if (!rst && load_valid && load_ready) begin
            exp_q.push_back(word_in);
            xfer_cnt++;
        end
    end

    always @(posedge rst) exp_q.delete();

    always @(negedge sc) begin
        if (frame_done) begin
            fd_count++;
            check("fd_one_cycle", fd_prev, 1'b0);
            check("fd_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("frame_q", q_ds, exp_q.pop_front());
        end
        fd_prev = frame_done;
    end

    task automatic push_word(input logic [15:0] w);
        int start;
        int n;
        word_in    = w;
        load_valid = 1'b1;
        start      = xfer_cnt;
        n          = 0;
        while (xfer_cnt == start && n < 60) begin
            @(negedge sc);
            n++;
        end
        check("push_timeout", xfer_cnt != start, 1'b1);
    endtask

    task automatic capture(output logic [31:0] w, output int lead);
        lead = 0;
        w    = '0;
        while (!shift_en && lead < 40) begin
            @(negedge sc);
            lead++;
        end
        for (int i = 0; i < 16; i++) begin
            check("cap_shift_en", shift_en, 1'b1);
            w = {w[30:0], d_out};
            if (i < 15) @(negedge sc);
        end
    endtask

    task automatic wait_quiet();
        int n;
        logic quiet;
        quiet = 1'b0;
        n = 0;
        while (!quiet && n < 60) begin
            @(negedge sc);
            n++;
            quiet = !shift_en && !frame_done;
        end
        check("quiet_timeout", quiet, 1'b1);
    endtask

    initial begin
        logic [31:0] w;
        int lead, idle, fds, start, rdy;

        // Reset state
        #3;
        check("rst_ready", load_ready, 1'b0);
        check("rst_shift_en", shift_en, 1'b0);
        check("rst_d_out", d_out, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        @(negedge sc);
        rst = 1'b0;
        #1;
        check("idle_ready", load_ready, 1'b1);

        // Single frame
        push_word(16'hA5C3);
        load_valid = 1'b0;
        capture(w, lead);
        check("t1_bits", w, 32'hA5C3);
        check("t1_lead", lead, 0);
        @(negedge sc);
        check("t1_done", frame_done, 1'b1);
        check("t1_shift_off", shift_en, 1'b0);
        @(negedge sc);
        check("t1_done_low", frame_done, 1'b0);

        // Back-to-back with load_valid held
        push_word(16'h0001);
        word_in = 16'hFFFE;
        start = xfer_cnt;
        idle = 0;
        fds = 0;
        for (int n = 0; n < 80 && fds < 2; n++) begin
            if (xfer_cnt != start) load_valid = 1'b0;
            if (!shift_en) idle++;
            if (frame_done) fds++;
            if (fds < 2) @(negedge sc);
        end
        load_valid = 1'b0;
        check("t2_frames", fds, 2);
        check("t2_gap", idle - 1, SKID ? 0 : 1);

        // Backpressure
        @(negedge sc);
        push_word(16'h1234);
        word_in = 16'h5678;
        start = xfer_cnt;
        rdy = 0;
        for (int i = 1; i <= 16; i++) begin
            rdy += int'(load_ready);
            if (xfer_cnt != start) load_valid = 1'b0;
            if (i < 16) @(negedge sc);
        end
        check("t3_ready_cycles", rdy, SKID ? 1 : 0);
        if (SKID == 0) begin
            @(negedge sc);
            check("t3_ready_gap", load_ready, 1'b1);
            @(negedge sc);
        end
        check("t3_xfer", xfer_cnt - start, 1);
        load_valid = 1'b0;
        wait_quiet();

        // Mid-frame reset; a second word is offered (held in skid builds) and must be discarded
        push_word(16'hBEEF);
        word_in = 16'hCAFE;
        repeat (4) @(negedge sc);
        check("t4_bit4", d_out, 1'b1);
        #2;
        rst = 1'b1;
        load_valid = 1'b0;
        #1;
        check("t4_rst_d_out", d_out, 1'b0);
        check("t4_rst_shift_en", shift_en, 1'b0);
        check("t4_rst_ready", load_ready, 1'b0);
        check("t4_rst_fd", frame_done, 1'b0);
        @(negedge sc);
        rst = 1'b0;
        repeat (3) @(negedge sc);
        push_word(16'h00FF);
        load_valid = 1'b0;
        capture(w, lead);
        check("t4_bits", w, 32'h00FF);
        @(negedge sc);
        check("t4_done", frame_done, 1'b1);

        // WIDTH=8 instance
        @(negedge sc);
        w8_word  = 8'h81;
        w8_valid = 1'b1;
        check("w8_ready", w8_ready, 1'b1);
        @(negedge sc);
        w8_valid = 1'b0;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            check("w8_shift_en", w8_sen, 1'b1);
            check("w8_fd_early", w8_fd, 1'b0);
            w = {w[30:0], w8_dout};
            if (i < 7) @(negedge sc);
        end
        check("w8_bits", w, 32'h81);
        @(negedge sc);
        check("w8_done", w8_fd, 1'b1);
        check("w8_shift_off", w8_sen, 1'b0);
        @(negedge sc);
        check("w8_done_low", w8_fd, 1'b0);

        repeat (3) @(negedge sc);
        #1;
        check("fd_total", fd_count, 6);
        check("q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
